// File: rtl/char_ram_arbiter.sv
// char_ram_arbiter: shares one single-port char RAM between display reads (always win) and a buffered host write FIFO.
// Optional ARB_STATS_EN adds statStall, a saturating count of cycles the host queue waits behind display reads.
module char_ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic pixelClk,
  input  logic reset,
  input  logic dispReq,
  input  logic [ADDR_W-1:0] dispAddr,
  output logic [DATA_W-1:0] dispData,
  output logic dispValid,
  input  logic hostWrReq,
  input  logic [ADDR_W-1:0] hostAddr,
  input  logic [DATA_W-1:0] hostData,
  output logic hostReady,
  output logic [$clog2(FIFO_DEPTH):0] fifoCount,
`ifdef ARB_STATS_EN
  output logic [15:0] statStall,
`endif
  output logic [ADDR_W-1:0] ramAddr,
  output logic ramWe,
  output logic [DATA_W-1:0] ramWdata,
  input  logic [DATA_W-1:0] ramRdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {G_IDLE, G_DISP, G_HOST} gnt_t;
  gnt_t gnt, gntNext;
  logic [ADDR_W-1:0] qAddr [FIFO_DEPTH];
  logic [DATA_W-1:0] qData [FIFO_DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic push, pop, rdPend;
  always_ff @(posedge pixelClk or posedge reset)
    if (reset) gnt <= G_IDLE;
    else gnt <= gntNext;
  always_comb gntNext = dispReq ? G_DISP : (fifoCount != '0) ? G_HOST : G_IDLE;
  always_comb begin
    hostReady = fifoCount != FULL;
    push = hostWrReq && hostReady;
    pop = gntNext == G_HOST;
  end
  always_ff @(posedge pixelClk)
    if (push) begin
      qAddr[wrPtr] <= hostAddr;
      qData[wrPtr] <= hostData;
    end
  always_ff @(posedge pixelClk or posedge reset)
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      fifoCount <= '0;
    end else begin
      wrPtr <= wrPtr + PW'(push);
      rdPtr <= rdPtr + PW'(pop);
      fifoCount <= fifoCount + (PW+1)'(push) - (PW+1)'(pop);
    end
  // rdPend marks the cycle in which ramRdata answers the previous display grant
  always_ff @(posedge pixelClk or posedge reset)
    if (reset) begin
      ramAddr <= '0;
      ramWe <= 1'b0;
      ramWdata <= '0;
      rdPend <= 1'b0;
      dispValid <= 1'b0;
      dispData <= '0;
    end else begin
      ramWe <= pop;
      if (gntNext == G_DISP) ramAddr <= dispAddr;
      else if (pop) begin
        ramAddr <= qAddr[rdPtr];
        ramWdata <= qData[rdPtr];
      end
      rdPend <= gnt == G_DISP;
      dispValid <= rdPend;
      if (rdPend) dispData <= ramRdata;
    end
`ifdef ARB_STATS_EN
  always_ff @(posedge pixelClk or posedge reset)
    if (reset) statStall <= '0;
    else if (dispReq && fifoCount != '0 && statStall != 16'hFFFF) statStall <= statStall + 16'd1;
`endif
endmodule

// File: tb/tb_char_ram_arbiter.sv
// tb_char_ram_arbiter: vector table, corner sequences and random traffic against a queue-based model of char_ram_arbiter.
module tb_char_ram_arbiter;
  localparam int AW = 12, DW = 8, D = 4;
  logic pixelClk = 1'b0, reset = 1'b0, dispReq = 1'b0, hostWrReq = 1'b0;
  logic [AW-1:0] dispAddr = '0, hostAddr = '0, ramAddr;
  logic [DW-1:0] hostData = '0, dispData, ramWdata, ramRdata = '0;
  logic dispValid, hostReady, ramWe;
  logic [2:0] fifoCount;
`ifdef ARB_STATS_EN
  logic [15:0] statStall;
  logic [15:0] stallBase;
`endif
  int checks = 0, errors = 0;
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] refMem [4096];
  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t q[$];
  logic s0v, s1v, expWe, expValid;
  logic [DW-1:0] s0d, s1d, expWdata, expData;
  logic [AW-1:0] expAddr;
  int expStall;
  typedef struct {
    logic dr; logic [AW-1:0] da; logic hr; logic [AW-1:0] ha; logic [DW-1:0] hd;
    logic we; logic [AW-1:0] ra; logic [DW-1:0] wd; logic v; logic [DW-1:0] dd; int cnt;
  } vec_t;
  vec_t vt[11];

  char_ram_arbiter dut (
    .pixelClk(pixelClk), .reset(reset), .dispReq(dispReq), .dispAddr(dispAddr),
    .dispData(dispData), .dispValid(dispValid), .hostWrReq(hostWrReq), .hostAddr(hostAddr),
    .hostData(hostData), .hostReady(hostReady), .fifoCount(fifoCount),
`ifdef ARB_STATS_EN
    .statStall(statStall),
`endif
    .ramAddr(ramAddr), .ramWe(ramWe), .ramWdata(ramWdata), .ramRdata(ramRdata)
  );

  always #5 pixelClk = ~pixelClk;

  // single-port synchronous RAM, read data one cycle after address
  always @(posedge pixelClk) begin
    if (ramWe) mem[ramAddr] <= ramWdata;
    ramRdata <= mem[ramAddr];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    s0v = 0; s1v = 0; s0d = '0; s1d = '0;
    expWe = 0; expValid = 0; expAddr = '0; expWdata = '0; expData = '0; expStall = 0;
  endtask

  // model: display reads return RAM contents two edges later; queued writes drain in order on free edges
  task automatic drive(input logic dr, input logic [AW-1:0] da, input logic hr,
                       input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    int n;
    @(negedge pixelClk);
    dispReq = dr; dispAddr = da; hostWrReq = hr; hostAddr = ha; hostData = hd;
    n = q.size();
    if (dr && n > 0 && expStall < 65535) expStall++;
    expValid = s1v;
    if (s1v) expData = s1d;
    s1v = s0v; s1d = s0d;
    s0v = dr; s0d = refMem[da];
    expWe = !dr && n > 0;
    if (dr) expAddr = da;
    else if (n > 0) begin
      wr_t e;
      e = q.pop_front();
      refMem[e.a] = e.d;
      expAddr = e.a;
      expWdata = e.d;
    end
    if (hr && n < D) q.push_back('{ha, hd});
    @(posedge pixelClk);
    #1;
  endtask

  task automatic chkModel(input string tag);
    chk({tag, ".ramWe"}, ramWe, expWe);
    chk({tag, ".ramAddr"}, ramAddr, expAddr);
    chk({tag, ".ramWdata"}, ramWdata, expWdata);
    chk({tag, ".dispValid"}, dispValid, expValid);
    chk({tag, ".dispData"}, dispData, expData);
    chk({tag, ".fifoCount"}, fifoCount, q.size());
    chk({tag, ".hostReady"}, hostReady, q.size() != D);
`ifdef ARB_STATS_EN
    chk({tag, ".statStall"}, statStall, expStall);
`endif
  endtask

  task automatic chkResetVals(input string tag);
    chk({tag, ".dispValid"}, dispValid, 0);
    chk({tag, ".dispData"}, dispData, 0);
    chk({tag, ".ramWe"}, ramWe, 0);
    chk({tag, ".ramAddr"}, ramAddr, 0);
    chk({tag, ".ramWdata"}, ramWdata, 0);
    chk({tag, ".fifoCount"}, fifoCount, 0);
    chk({tag, ".hostReady"}, hostReady, 1);
`ifdef ARB_STATS_EN
    chk({tag, ".statStall"}, statStall, 0);
`endif
  endtask

  initial begin
    vt[0]  = '{1'b1, 12'h010, 1'b0, 12'h000, 8'h00, 1'b0, 12'h010, 8'h00, 1'b0, 8'h00, 0};
    vt[1]  = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 12'h010, 8'h00, 1'b0, 8'h00, 0};
    vt[2]  = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 12'h010, 8'h00, 1'b1, 8'h41, 0};
    vt[3]  = '{1'b0, 12'h000, 1'b1, 12'h123, 8'h5A, 1'b0, 12'h010, 8'h00, 1'b0, 8'h41, 1};
    vt[4]  = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b1, 12'h123, 8'h5A, 1'b0, 8'h41, 0};
    vt[5]  = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 12'h123, 8'h5A, 1'b0, 8'h41, 0};
    vt[6]  = '{1'b1, 12'h020, 1'b1, 12'h200, 8'h11, 1'b0, 12'h020, 8'h5A, 1'b0, 8'h41, 1};
    vt[7]  = '{1'b1, 12'h123, 1'b0, 12'h000, 8'h00, 1'b0, 12'h123, 8'h5A, 1'b0, 8'h41, 1};
    vt[8]  = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b1, 12'h200, 8'h11, 1'b1, 8'h77, 0};
    vt[9]  = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 12'h200, 8'h11, 1'b1, 8'h5A, 0};
    vt[10] = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, 1'b0, 12'h200, 8'h11, 1'b0, 8'h5A, 0};
    for (int i = 0; i < 4096; i++) mem[i] = DW'(i * 3 + 1);
    mem[12'h010] = 8'h41;
    mem[12'h020] = 8'h77;
    refMem = mem;
    modelReset();
    #1 reset = 1'b1;
    #1 chkResetVals("por");
    @(negedge pixelClk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(vt[i].dr, vt[i].da, vt[i].hr, vt[i].ha, vt[i].hd);
      chk($sformatf("vec%0d.ramWe", i), ramWe, vt[i].we);
      chk($sformatf("vec%0d.ramAddr", i), ramAddr, vt[i].ra);
      chk($sformatf("vec%0d.ramWdata", i), ramWdata, vt[i].wd);
      chk($sformatf("vec%0d.dispValid", i), dispValid, vt[i].v);
      chk($sformatf("vec%0d.dispData", i), dispData, vt[i].dd);
      chk($sformatf("vec%0d.fifoCount", i), fifoCount, vt[i].cnt);
    end

    // display priority: two writes wait behind six display cycles
    drive(1'b1, 12'h300, 1'b1, 12'h0A1, 8'hC1);
    chk("prio.we0", ramWe, 0);
    drive(1'b1, 12'h301, 1'b1, 12'h0A2, 8'hC2);
    chk("prio.we1", ramWe, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(12'h302 + i), 1'b0, '0, '0);
      chk("prio.weHeld", ramWe, 0);
      chkModel("prio");
    end
    drive(1'b0, '0, 1'b0, '0, '0);
    chk("prio.first.we", ramWe, 1);
    chk("prio.first.addr", ramAddr, 12'h0A1);
    chk("prio.first.data", ramWdata, 8'hC1);
    drive(1'b0, '0, 1'b0, '0, '0);
    chk("prio.second.we", ramWe, 1);
    chk("prio.second.addr", ramAddr, 12'h0A2);
    chk("prio.second.data", ramWdata, 8'hC2);
    repeat (3) begin
      drive(1'b0, '0, 1'b0, '0, '0);
      chkModel("prio.tail");
    end

    // full FIFO: fifth push while full must be dropped
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, AW'(12'h310 + i), 1'b1, AW'(12'h0B0 + i), DW'(8'hD0 + i));
      chkModel("fill");
    end
    chk("full.count", fifoCount, 4);
    chk("full.ready", hostReady, 0);
    drive(1'b0, '0, 1'b0, '0, '0);
    chk("full.firstPopReady", hostReady, 1);
    chk("full.firstPopAddr", ramAddr, 12'h0B0);
    repeat (5) begin
      drive(1'b0, '0, 1'b0, '0, '0);
      chkModel("drain");
    end
    chk("drain.lastAddr", ramAddr, 12'h0B3);

`ifdef ARB_STATS_EN
    stallBase = statStall;
    drive(1'b1, 12'h005, 1'b1, 12'h0E0, 8'h99);
    repeat (10) drive(1'b1, 12'h006, 1'b0, '0, '0);
    chk("stats.ten", statStall, stallBase + 16'd10);
    repeat (4) begin
      drive(1'b0, '0, 1'b0, '0, '0);
      chkModel("stats.drain");
    end
`endif

    // asynchronous reset mid-traffic: pending read and a write in flight
    drive(1'b1, 12'h050, 1'b1, 12'h0C0, 8'hE0);
    drive(1'b1, 12'h051, 1'b1, 12'h0C1, 8'hE1);
    drive(1'b0, '0, 1'b0, '0, '0);
    chk("pre.ramWe", ramWe, 1);
    chk("pre.dispValid", dispValid, 1);
    #2 reset = 1'b1;
    #1 chkResetVals("midrst");
    @(negedge pixelClk);
    reset = 1'b0;
    modelReset();
    drive(1'b0, '0, 1'b0, '0, '0);
    chkModel("postrst");

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 99) < 45, AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 31)), DW'($urandom));
      chkModel("rand");
    end
    repeat (8) begin
      drive(1'b0, '0, 1'b0, '0, '0);
      chkModel("final");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
